// File: rtl/alu_src2_pkg.sv
// alu_src2 shared definitions: operand-B select codes, forwarding
// select codes and the skid-buffer FSM state encoding.
package alu_src2_pkg;

  localparam logic [2:0] OP2_RS2   = 3'd0;
  localparam logic [2:0] OP2_IMMI  = 3'd1;
  localparam logic [2:0] OP2_IMMS  = 3'd2;
  localparam logic [2:0] OP2_SHAMT = 3'd3;
  localparam logic [2:0] OP2_IMMU  = 3'd4;
  localparam logic [2:0] OP2_IMMB  = 3'd5;
  localparam logic [2:0] OP2_IMMJ  = 3'd6;
  localparam logic [2:0] OP2_ILL   = 3'd7;

  localparam logic [1:0] FWD_RS2   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;
  localparam logic [1:0] FWD_RS2B  = 2'd3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_src2_stage_imm_gen.sv
// Immediate generator: decodes the RV32I immediate selected by op2_sel.
// RS2 and illegal selects yield zero (the operand comes from forwarding).
module imm_gen
  import alu_src2_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      op2_sel,
  output logic [XLEN-1:0] imm
);

  logic signed [31:0] imm_i;
  logic signed [31:0] imm_s;
  logic signed [31:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [31:0] imm_j;
  logic               unused_low;

  assign unused_low = ^instr[6:0];

  assign imm_i = 32'($signed(instr[31:20]));
  assign imm_s = 32'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = 32'($signed({instr[31], instr[7],
                              instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = $signed({instr[31:12], 12'b0});
  assign imm_j = 32'($signed({instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0}));

  // Signed casts sign-extend to XLEN; shamt stays unsigned.
  always_comb begin
    imm = '0;
    unique case (1'b1)
      op2_sel == OP2_IMMI:  imm = XLEN'(imm_i);
      op2_sel == OP2_IMMS:  imm = XLEN'(imm_s);
      op2_sel == OP2_SHAMT: imm = XLEN'(instr[20 +: SHAMT_W]);
      op2_sel == OP2_IMMU:  imm = XLEN'(imm_u);
      op2_sel == OP2_IMMB:  imm = XLEN'(imm_b);
      op2_sel == OP2_IMMJ:  imm = XLEN'(imm_j);
      default:              imm = '0;
    endcase
  end

endmodule

// File: rtl/alu_src2_stage.sv
// EX-stage operand-B generator with forwarding and a 2-entry skid buffer.
// Optional flush input enabled by defining ALU_SRC2_FLUSH_EN.
module alu_src2_stage
  import alu_src2_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef ALU_SRC2_FLUSH_EN
  input  logic            flush,
`endif
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op2_sel,
  input  logic [31:0]     instr,
  input  logic [1:0]      fwd_sel,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] ex_mem_data,
  input  logic [XLEN-1:0] mem_wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_operand,
  output logic            out_illegal
);

  state_t          state;
  state_t          state_nx;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] fwd_val;
  logic [XLEN-1:0] cap_op;
  logic            cap_ill;
  logic [XLEN-1:0] main_op;
  logic [XLEN-1:0] skid_op;
  logic            main_ill;
  logic            skid_ill;
  logic            in_x;
  logic            out_x;

  imm_gen #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_imm_gen (
    .instr   (instr),
    .op2_sel (op2_sel),
    .imm     (imm)
  );

  always_comb begin
    fwd_val = rs2_data;
    unique case (1'b1)
      fwd_sel == FWD_EXMEM: fwd_val = ex_mem_data;
      fwd_sel == FWD_MEMWB: fwd_val = mem_wb_data;
      default:              fwd_val = rs2_data;
    endcase
  end

  assign cap_ill = (op2_sel == OP2_ILL);
  assign cap_op  = (op2_sel == OP2_RS2 || cap_ill) ? fwd_val : imm;

  assign in_x  = in_valid & in_ready;
  assign out_x = out_valid & out_ready;

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state == ST_EMPTY: begin
        if (in_x) state_nx = ST_ONE;
      end
      state == ST_ONE: begin
        if (in_x && !out_x)      state_nx = ST_FULL;
        else if (!in_x && out_x) state_nx = ST_EMPTY;
      end
      state == ST_FULL: begin
        if (out_x) state_nx = ST_ONE;
      end
      default: state_nx = ST_EMPTY;
    endcase
`ifdef ALU_SRC2_FLUSH_EN
    if (flush) state_nx = ST_EMPTY;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      main_op   <= '0;
      main_ill  <= 1'b0;
      skid_op   <= '0;
      skid_ill  <= 1'b0;
    end else begin
      state     <= state_nx;
      out_valid <= (state_nx != ST_EMPTY);
      in_ready  <= (state_nx != ST_FULL);
      // Main advances only when empty or its current entry leaves.
      if (state == ST_FULL && out_x) begin
        main_op  <= skid_op;
        main_ill <= skid_ill;
      end else if (in_x && (state == ST_EMPTY || out_x)) begin
        main_op  <= cap_op;
        main_ill <= cap_ill;
      end
      if (in_x && state == ST_ONE && !out_x) begin
        skid_op  <= cap_op;
        skid_ill <= cap_ill;
      end
    end
  end

  assign out_operand = main_op;
  assign out_illegal = main_ill;

endmodule

// File: tb/tb_alu_src2_stage.sv
// Directed self-checking bench for alu_src2_stage.
// Flush checks run when ALU_SRC2_FLUSH_EN is defined.
module tb_alu_src2_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op2_sel;
  logic [31:0] instr;
  logic [1:0]  fwd_sel;
  logic [31:0] rs2_data;
  logic [31:0] ex_mem_data;
  logic [31:0] mem_wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_operand;
  logic        out_illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_src2_stage #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef ALU_SRC2_FLUSH_EN
    .flush       (flush),
`endif
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op2_sel     (op2_sel),
    .instr       (instr),
    .fwd_sel     (fwd_sel),
    .rs2_data    (rs2_data),
    .ex_mem_data (ex_mem_data),
    .mem_wb_data (mem_wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_operand (out_operand),
    .out_illegal (out_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] s, input logic [31:0] ins,
                      input logic [1:0] f);
    in_valid = 1'b1;
    op2_sel  = s;
    instr    = ins;
    fwd_sel  = f;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    op2_sel     = 3'd0;
    instr       = 32'h0;
    fwd_sel     = 2'd0;
    rs2_data    = 32'h11;
    ex_mem_data = 32'h22;
    mem_wb_data = 32'h33;
    out_ready   = 1'b1;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_oper", out_operand, 32'h0);
    chk("rst_ill", 32'(out_illegal), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    send(3'd1, 32'hFFF00093, 2'd0);
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi", out_operand, 32'hFFFFFFFF);
    chk("addi_ill", 32'(out_illegal), 32'd0);
    send(3'd1, 32'h00500093, 2'd0);
    chk("addi_pos", out_operand, 32'h00000005);
    send(3'd2, 32'hFE112E23, 2'd0);
    chk("sw", out_operand, 32'hFFFFFFFC);
    send(3'd4, 32'h123450B7, 2'd0);
    chk("lui", out_operand, 32'h12345000);
    send(3'd3, 32'h41F0D093, 2'd0);
    chk("srai", out_operand, 32'h0000001F);
    send(3'd3, 32'hFFF0D093, 2'd0);
    chk("shamt_zx", out_operand, 32'h0000001F);
    send(3'd5, 32'hFE000EE3, 2'd0);
    chk("beq_neg", out_operand, 32'hFFFFFFFC);
    send(3'd6, 32'h0080006F, 2'd0);
    chk("jal_pos", out_operand, 32'h00000008);
    send(3'd6, 32'hFFDFF06F, 2'd0);
    chk("jal_neg", out_operand, 32'hFFFFFFFC);

    send(3'd0, 32'hFFFFFFFF, 2'd0);
    chk("fwd0", out_operand, 32'h11);
    send(3'd0, 32'hFFFFFFFF, 2'd1);
    chk("fwd1", out_operand, 32'h22);
    send(3'd0, 32'hFFFFFFFF, 2'd2);
    chk("fwd2", out_operand, 32'h33);
    send(3'd0, 32'hFFFFFFFF, 2'd3);
    chk("fwd3", out_operand, 32'h11);
    send(3'd7, 32'hFFF00093, 2'd1);
    chk("ill_oper", out_operand, 32'h22);
    chk("ill_flag", 32'(out_illegal), 32'd1);
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: A,B fill both entries, C waits.
    out_ready = 1'b0;
    rs2_data = 32'hA;
    send(3'd0, 32'h0, 2'd0);
    chk("bp_a", out_operand, 32'hA);
    chk("bp_rdy_a", 32'(in_ready), 32'd1);
    rs2_data = 32'hB;
    send(3'd0, 32'h0, 2'd0);
    chk("bp_rdy_b", 32'(in_ready), 32'd0);
    rs2_data = 32'hC;
    in_valid = 1'b1;
    tick();
    tick();
    chk("bp_hold_rdy", 32'(in_ready), 32'd0);
    chk("bp_hold_a", out_operand, 32'hA);
    chk("bp_hold_v", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_b", out_operand, 32'hB);
    chk("bp_rdy_one", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_c", out_operand, 32'hC);
    chk("bp_c_v", 32'(out_valid), 32'd1);
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Reset while FULL.
    out_ready = 1'b0;
    rs2_data = 32'h5A;
    send(3'd0, 32'h0, 2'd0);
    send(3'd0, 32'h0, 2'd0);
    chk("full_rdy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_ready", 32'(in_ready), 32'd1);
    chk("mrst_oper", out_operand, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mrst_stay", 32'(out_valid), 32'd0);

`ifdef ALU_SRC2_FLUSH_EN
    send(3'd0, 32'h0, 2'd0);
    send(3'd0, 32'h0, 2'd0);
    chk("fl_full", 32'(in_ready), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    flush = 1'b1;
    send(3'd0, 32'h0, 2'd0);
    flush = 1'b0;
    chk("fl_discard", 32'(out_valid), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
